// File: rtl/sprite_compositor_if.sv
// Pixel-stream bundle for the sprite compositor: per-layer sprite flags and
// colours, background colour, display timing and fade control going in;
// final RGB, delayed timing and the per-frame collision report coming out.
interface sprite_compositor_if #(
    parameter int N_LAYERS = 4,
    parameter int COLR_W   = 24,
    parameter int FADE_W   = 4
);
    logic                         i_frame;
    logic                         i_line;
    logic                         i_de;
    logic                         i_hsync;
    logic                         i_vsync;
    logic [N_LAYERS-1:0]          i_layer_en;
    logic [N_LAYERS-1:0]          i_layer_drawing;
    logic [N_LAYERS-1:0]          i_layer_trans;
    logic [N_LAYERS*COLR_W-1:0]   i_layer_color;
    logic [23:0]                  i_bg_color;
    logic [FADE_W-1:0]            i_fade;

    logic [7:0]                   o_r;
    logic [7:0]                   o_g;
    logic [7:0]                   o_b;
    logic                         o_de;
    logic                         o_hsync;
    logic                         o_vsync;
    logic                         o_line;
    logic [N_LAYERS-1:0]          o_collide;
    logic                         o_collide_valid;

    // Compositor side: consumes the sprite/timing inputs, drives the pixel out.
    modport slave (
        input  i_frame, i_line, i_de, i_hsync, i_vsync,
        input  i_layer_en, i_layer_drawing, i_layer_trans, i_layer_color,
        input  i_bg_color, i_fade,
        output o_r, o_g, o_b, o_de, o_hsync, o_vsync, o_line,
        output o_collide, o_collide_valid
    );

    // Source side: the sprite stages and video timing generator.
    modport master (
        output i_frame, i_line, i_de, i_hsync, i_vsync,
        output i_layer_en, i_layer_drawing, i_layer_trans, i_layer_color,
        output i_bg_color, i_fade,
        input  o_r, o_g, o_b, o_de, o_hsync, o_vsync, o_line,
        input  o_collide, o_collide_valid
    );
endinterface

// File: rtl/sprite_compositor.sv
// Sprite compositor: two-stage pixel pipeline that picks the highest-priority
// opaque layer (or background), applies a per-frame fade, blanks outside the
// active area, and reports per-frame layer overlaps for game logic.
module sprite_compositor #(
    parameter int N_LAYERS = 4,
    parameter int COLR_W   = 24,
    parameter int FADE_W   = 4
) (
    input logic                i_clk_pix,
    input logic                i_rst_n,
    sprite_compositor_if.slave bus
);
    localparam int GAIN_W = FADE_W + 1;
    localparam int PROD_W = 8 + GAIN_W;

    // Scale one channel by (2^FADE_W - fade) / 2^FADE_W; never exceeds the input.
    function automatic logic [7:0] fade_scale(input logic [7:0] c, input logic [FADE_W-1:0] f);
        logic [GAIN_W-1:0] gain;
        logic [PROD_W-1:0] prod;
        gain = GAIN_W'(1 << FADE_W) - GAIN_W'(f);
        prod = PROD_W'(c) * PROD_W'(gain);
        return prod[FADE_W +: 8];
    endfunction

    // True when two or more bits are set.
    function automatic logic multi_hot(input logic [N_LAYERS-1:0] v);
        return (v & (v - N_LAYERS'(1))) != '0;
    endfunction

    logic [N_LAYERS-1:0] w_opq;
    logic                w_hit;
    logic [23:0]         w_sel_rgb;

    logic [23:0]         r_rgb_p1;
    logic                r_de_p1;
    logic                r_hsync_p1;
    logic                r_vsync_p1;
    logic                r_line_p1;
    logic [FADE_W-1:0]   r_fade;
    logic [N_LAYERS-1:0] r_acc;

    assign w_opq = bus.i_layer_en & bus.i_layer_drawing & ~bus.i_layer_trans;
    assign w_hit = bus.i_de & multi_hot(w_opq);

    // Priority select: walk from lowest priority up so layer 0 wins; layer
    // colours arrive as {R,B,G} and are reordered to {R,G,B}.
    always_comb begin
        w_sel_rgb = bus.i_bg_color;
        for (int k = N_LAYERS - 1; k >= 0; k--) begin
            if (w_opq[k]) begin
                w_sel_rgb = {bus.i_layer_color[COLR_W*k + 16 +: 8],
                             bus.i_layer_color[COLR_W*k      +: 8],
                             bus.i_layer_color[COLR_W*k +  8 +: 8]};
            end
        end
    end

    // Stage 1 boundary: selected colour plus timing.
    always_ff @(posedge i_clk_pix or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rgb_p1   <= '0;
            r_de_p1    <= 1'b0;
            r_hsync_p1 <= 1'b0;
            r_vsync_p1 <= 1'b0;
            r_line_p1  <= 1'b0;
        end else begin
            r_rgb_p1   <= w_sel_rgb;
            r_de_p1    <= bus.i_de;
            r_hsync_p1 <= bus.i_hsync;
            r_vsync_p1 <= bus.i_vsync;
            r_line_p1  <= bus.i_line;
        end
    end

    // Fade level is captured only on the frame pulse so it never changes mid-frame.
    always_ff @(posedge i_clk_pix or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fade <= '0;
        end else if (bus.i_frame) begin
            r_fade <= bus.i_fade;
        end
    end

    // Stage 2 boundary: faded, blanked colour and timing to the outputs.
    always_ff @(posedge i_clk_pix or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.o_r     <= '0;
            bus.o_g     <= '0;
            bus.o_b     <= '0;
            bus.o_de    <= 1'b0;
            bus.o_hsync <= 1'b0;
            bus.o_vsync <= 1'b0;
            bus.o_line  <= 1'b0;
        end else begin
            bus.o_r     <= r_de_p1 ? fade_scale(r_rgb_p1[23:16], r_fade) : 8'd0;
            bus.o_g     <= r_de_p1 ? fade_scale(r_rgb_p1[15:8],  r_fade) : 8'd0;
            bus.o_b     <= r_de_p1 ? fade_scale(r_rgb_p1[7:0],   r_fade) : 8'd0;
            bus.o_de    <= r_de_p1;
            bus.o_hsync <= r_hsync_p1;
            bus.o_vsync <= r_vsync_p1;
            bus.o_line  <= r_line_p1;
        end
    end

    // Collision accumulation; the frame pulse reports the old frame and seeds
    // the new one with its own cycle's overlap.
    always_ff @(posedge i_clk_pix or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc               <= '0;
            bus.o_collide       <= '0;
            bus.o_collide_valid <= 1'b0;
        end else if (bus.i_frame) begin
            bus.o_collide       <= r_acc;
            bus.o_collide_valid <= 1'b1;
            r_acc               <= w_hit ? w_opq : '0;
        end else begin
            bus.o_collide_valid <= 1'b0;
            if (w_hit) begin
                r_acc <= r_acc | w_opq;
            end
        end
    end
endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for the sprite compositor with a pixel scoreboard and a
// reference model of fade and collision behaviour.
module tb_sprite_compositor;
    localparam int NL = 4;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       de;
        logic       hs;
        logic       vs;
        logic       ln;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    exp_t    q[$];
    logic [3:0]    fade_m;
    logic [NL-1:0] acc_m;
    logic [NL-1:0] col_m;
    logic          vld_m;

    sprite_compositor_if #(.N_LAYERS(NL), .COLR_W(24), .FADE_W(4)) bus ();

    sprite_compositor #(.N_LAYERS(NL), .COLR_W(24), .FADE_W(4)) dut (
        .i_clk_pix (clk),
        .i_rst_n   (rst_n),
        .bus       (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        q.delete();
        q.push_back('0);
        fade_m = '0;
        acc_m  = '0;
        col_m  = '0;
        vld_m  = 1'b0;
    endtask

    function automatic logic [7:0] scale(input logic [7:0] c, input logic [3:0] f);
        int v;
        v = (int'(c) * (16 - int'(f))) / 16;
        return 8'(v);
    endfunction

    // One pixel clock: predict, clock, compare the pixel from two cycles ago.
    task automatic cycle();
        exp_t          e;
        exp_t          got;
        logic [NL-1:0] opq;
        logic [23:0]   c;
        logic [23:0]   rgb;
        logic          found;
        logic          hit;
        opq = bus.i_layer_en & bus.i_layer_drawing & ~bus.i_layer_trans;
        if (bus.i_frame) fade_m = bus.i_fade;
        rgb   = bus.i_bg_color;
        found = 1'b0;
        for (int k = 0; k < NL; k++) begin
            if (!found && opq[k]) begin
                found = 1'b1;
                c     = bus.i_layer_color[24*k +: 24];
                rgb   = {c[23:16], c[7:0], c[15:8]};
            end
        end
        e.r  = bus.i_de ? scale(rgb[23:16], fade_m) : 8'd0;
        e.g  = bus.i_de ? scale(rgb[15:8],  fade_m) : 8'd0;
        e.b  = bus.i_de ? scale(rgb[7:0],   fade_m) : 8'd0;
        e.de = bus.i_de;
        e.hs = bus.i_hsync;
        e.vs = bus.i_vsync;
        e.ln = bus.i_line;
        q.push_back(e);
        hit = bus.i_de && ($countones(opq) >= 2);
        if (bus.i_frame) begin
            col_m = acc_m;
            vld_m = 1'b1;
            acc_m = hit ? opq : '0;
        end else begin
            vld_m = 1'b0;
            if (hit) acc_m = acc_m | opq;
        end
        @(posedge clk);
        #1;
        if (q.size() == 2) begin
            e   = q.pop_front();
            got = {bus.o_r, bus.o_g, bus.o_b, bus.o_de, bus.o_hsync, bus.o_vsync, bus.o_line};
            chk("pixel_rgb",    32'(got[30:7]), 32'(e[30:7]));
            chk("pixel_timing", 32'(got[3:0]),  32'(e[3:0]));
        end else begin
            chk("scoreboard_depth", 32'(q.size()), 32'd2);
        end
        chk("collide",       32'(bus.o_collide),       32'(col_m));
        chk("collide_valid", 32'(bus.o_collide_valid), 32'(vld_m));
    endtask

    task automatic frame_pulse();
        bus.i_de    = 1'b0;
        bus.i_frame = 1'b1;
        cycle();
        bus.i_frame = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {bus.o_r, bus.o_g, bus.o_b, 8'(bus.o_collide)}, 32'd0);
        chk({tag, "_ctl"}, 32'({bus.o_de, bus.o_hsync, bus.o_vsync, bus.o_line, bus.o_collide_valid}), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.i_frame = 0; bus.i_line = 0; bus.i_de = 0; bus.i_hsync = 0; bus.i_vsync = 0;
        bus.i_layer_en = '0; bus.i_layer_drawing = '0; bus.i_layer_trans = '0;
        bus.i_layer_color = '0; bus.i_bg_color = '0; bus.i_fade = '0;
        model_reset();

        // Reset state
        #12;
        chk_all_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // First frame after reset: nothing accumulated
        frame_pulse();
        run(2);

        // Background only
        bus.i_layer_en = 4'b1111;
        bus.i_bg_color = 24'h336699;
        bus.i_de       = 1'b1;
        run(3);
        chk("bg_r_direct", 32'(bus.o_r), 32'h33);
        chk("bg_g_direct", 32'(bus.o_g), 32'h66);
        chk("bg_b_direct", 32'(bus.o_b), 32'h99);

        // Priority: layers 1 and 2 opaque, layer 1 wins
        bus.i_layer_drawing = 4'b0110;
        bus.i_layer_color   = {24'h0, 24'h123456, 24'hFF0080, 24'h0};
        bus.i_line          = 1'b1;
        cycle();
        bus.i_line          = 1'b0;
        run(2);
        chk("prio_rgb_direct", {8'h0, bus.o_r, bus.o_g, bus.o_b}, 32'hFF8000);
        bus.i_layer_drawing = '0;
        frame_pulse();
        chk("prio_collide_direct", 32'(bus.o_collide), 32'h6);
        run(2);

        // Transparent layer 0 and disabled layer 1 fall through to background
        bus.i_de            = 1'b1;
        bus.i_layer_en      = 4'b1101;
        bus.i_layer_drawing = 4'b0011;
        bus.i_layer_trans   = 4'b0001;
        run(3);
        chk("trans_bg_direct", {8'h0, bus.o_r, bus.o_g, bus.o_b}, 32'h336699);
        frame_pulse();
        chk("trans_collide_direct", 32'(bus.o_collide), 32'h0);
        bus.i_layer_trans = '0;
        bus.i_layer_en    = 4'b1111;

        // Fade set between frames, applied at the frame pulse
        bus.i_fade = 4'd8;
        run(1);
        frame_pulse();
        bus.i_layer_drawing = 4'b0001;
        bus.i_layer_color   = {24'h0, 24'h0, 24'h0, 24'hFF0280};
        bus.i_de            = 1'b1;
        run(3);
        chk("fade8_direct", {8'h0, bus.o_r, bus.o_g, bus.o_b}, 32'h7F4001);
        bus.i_fade = 4'd15;
        run(3);
        chk("fade_midframe_direct", {8'h0, bus.o_r, bus.o_g, bus.o_b}, 32'h7F4001);
        frame_pulse();
        bus.i_de = 1'b1;
        run(3);
        chk("fade15_direct", {8'h0, bus.o_r, bus.o_g, bus.o_b}, 32'h0F0800);
        bus.i_fade = 4'd0;
        frame_pulse();

        // Blanking: overlapping opaque layers with de low, sync pulses
        bus.i_de            = 1'b0;
        bus.i_layer_drawing = 4'b0011;
        run(2);
        bus.i_hsync = 1'b1;
        cycle();
        bus.i_hsync = 1'b0;
        bus.i_vsync = 1'b1;
        cycle();
        bus.i_vsync = 1'b0;
        run(2);
        frame_pulse();
        chk("blank_collide_direct", 32'(bus.o_collide), 32'h0);

        // Overlap on the frame cycle itself seeds the next frame
        bus.i_de    = 1'b1;
        bus.i_frame = 1'b1;
        bus.i_layer_drawing = 4'b1100;
        cycle();
        bus.i_frame = 1'b0;
        bus.i_layer_drawing = 4'b0011;
        run(2);
        bus.i_de = 1'b0;
        frame_pulse();
        chk("seed_collide_direct", 32'(bus.o_collide), 32'hF);

        // Async reset mid-line with accumulator nonzero
        bus.i_de = 1'b1;
        bus.i_layer_drawing = 4'b0101;
        run(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        bus.i_layer_drawing = '0;
        run(2);
        frame_pulse();
        chk("post_reset_collide_direct", 32'(bus.o_collide), 32'h0);
        chk("post_reset_valid_direct", 32'(bus.o_collide_valid), 32'h1);
        bus.i_de = 1'b1;
        run(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Downstream stage of the sprite stages. It consumes each sprite's drawing, transparent and colour outputs, plus the background colour and display timing.
- Resolves layer priority, applies a per-frame brightness fade, blanks outside the active area and drives final RGB with sync signals delay-matched.
- Also reports, once per frame, which layers overlapped with opaque pixels (collision mask) for game logic.

Parameters:
- N_LAYERS, 4, number of sprite layers; layer 0 has highest priority.
- COLR_W, 24, packed colour width per layer.
- FADE_W, 4, fade control width.

Ports:
- i_clk_pix  input  1  pixel clock
- i_rst_n  input  1  asynchronous active-low reset
- i_frame  input  1  one-cycle start-of-frame pulse (in blanking)
- i_line  input  1  one-cycle start-of-line pulse (unused functionally; delayed to o_line)
- i_de  input  1  active-video enable
- i_hsync  input  1  horizontal sync
- i_vsync  input  1  vertical sync
- i_layer_en  input  N_LAYERS  per-layer enable
- i_layer_drawing  input  N_LAYERS  per-layer drawing flag
- i_layer_trans  input  N_LAYERS  per-layer transparent flag
- i_layer_color  input  N_LAYERS*24  layer k at bits [24k+23:24k], packed {R,B,G}
- i_bg_color  input  24  background, packed {R,G,B}
- i_fade  input  FADE_W  0 = full brightness, 15 = 1/16 brightness
- o_r, o_g, o_b  output  8 each  final colour
- o_de, o_hsync, o_vsync, o_line  output  1 each  timing delayed 2 cycles
- o_collide  output  N_LAYERS  layers involved in any overlap during the previous frame
- o_collide_valid  output  1  one-cycle pulse when o_collide updates

Behaviour:
- Reset (async, i_rst_n low): all outputs 0, pipeline registers 0, fade register 0, collision accumulator 0.
- Opaque flag: opq[k] = i_layer_en[k] & i_layer_drawing[k] & ~i_layer_trans[k].
- Stage 1 (registered):
  - Select the lowest-index k with opq[k]=1.
  - Unpack that layer's colour from {R,B,G} to R,G,B.
  - If no layer is opaque, select i_bg_color (already {R,G,B}).
  - Register i_de, syncs and i_line alongside.
- Stage 2 (registered):
  - Each channel out = (c * (16 - fade_q)) >> 4, computed at 13-bit intermediate width, result 8 bits, no saturation needed. Example: fade 0 passes c unchanged; fade 8 halves; c=255 with fade 15 gives 15.
  - If the stage-1 delayed de is 0, o_r/o_g/o_b = 0.
- Latency: exactly 2 cycles from inputs to o_r/o_g/o_b/o_de/o_hsync/o_vsync/o_line. There is no handshake; the block streams one pixel per cycle.
- Fade register fade_q loads i_fade only on cycles with i_frame=1, so fade never changes mid-frame. Changes between frame pulses are ignored.
- Collision accumulator acc[N_LAYERS-1:0]:
  - On any cycle with i_de=1 and popcount(opq) >= 2: acc <= acc | opq.
  - On an i_frame cycle:
    - o_collide <= acc (the value before this cycle's update).
    - o_collide_valid <= 1 for that one cycle.
    - acc <= (i_de & popcount(opq) >= 2) ? opq : 0.
  - Net effect: i_frame has priority, and that cycle's own overlap seeds the new frame.
- Overlaps with i_de=0 are never counted. A disabled layer is never opaque and never counted.
- o_collide holds its value between valid pulses.
- Reset mid-frame clears the pipeline and acc immediately. The first post-reset i_frame reports only what accumulated since reset.
- Colour unpack: R = packed[23:16], G = packed[7:0], B = packed[15:8].

Test Plan:
- Background only: en=4'b1111, no drawing, bg=24'h336699, fade=0, de=1 -> two cycles later o_r=8'h33, o_g=8'h66, o_b=8'h99, o_de=1.
- Priority: layers 1 and 2 opaque, layer1 color {R=FF,B=00,G=80}, layer2 other -> o_r=FF, o_g=80, o_b=00, and at the next i_frame o_collide=4'b0110 with o_collide_valid pulsing for 1 cycle.
- Transparent/disabled: layer0 drawing but trans=1, layer1 opaque with en=0 -> background colour out, and the next o_collide=0.
- Fade: i_fade=8 set between frames, then i_frame, then pixel 255,128,2 -> 127,64,1. Changing i_fade to 15 mid-frame leaves output unchanged until the next i_frame.
- Blanking: opaque layer with i_de=0 -> RGB 0 and no collision counted. Syncs emerge exactly 2 cycles delayed (pulse at cycle 10 in gives cycle 12 out).
- Async reset asserted mid-line with acc nonzero -> all outputs 0 without a clock edge. After release, the first i_frame gives o_collide=0.
